cache_ctrl: RTL

Responder end of the MIU-to-cache request interface: accepts single-byte load/store requests issued by the MIU, services them from a small direct-mapped, write-through, write-allocate byte cache, and returns one response pulse per request. It sits between the MIU and the backing memory. The backing-memory side is a simple request/acknowledge port.

---
 rtl/cache_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: MIU-facing byte cache responder.
// Direct-mapped, write-through, write-allocate cache with one byte per line.
// Loads that hit are answered from the cache. Misses and all stores go to
// backing memory over a request/acknowledge port.
// Optional feature macro: CACHE_STATS_EN enables the saturating hit/miss
// counters. When it is undefined, hit_count and miss_count are tied to zero.
// The address width is a parameter that tracks the system-wide address width.
module cache_ctrl #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 8,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              resetN,
  // MIU request/response
  input  logic              cache_req_valid,
  output logic              cache_req_ready,
  input  logic              cache_req_we,
  input  logic [ADDR_W-1:0] cache_req_addr,
  input  logic [7:0]        cache_req_write,
  output logic              cache_resp_valid,
  output logic [7:0]        cache_resp_data,
  // backing memory
  output logic              bm_req,
  output logic              bm_we,
  output logic [ADDR_W-1:0] bm_addr,
  output logic [7:0]        bm_wdata,
  input  logic              bm_ack,
  input  logic [7:0]        bm_rdata,
  // statistics
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [7:0]          resp_data_q, resp_data_d;
  logic                bm_req_q, bm_req_d;
  logic                bm_we_q, bm_we_d;
  logic [ADDR_W-1:0]   bm_addr_q, bm_addr_d;
  logic [7:0]          bm_wdata_q, bm_wdata_d;

  // Line storage: valid bits need reset, tag/data live in plain arrays.
  logic                valid_q [LINES];
  logic                valid_d [LINES];
  logic [TAG_W-1:0]    tag_mem [LINES];
  logic [7:0]          data_mem [LINES];
  logic [TAG_W-1:0]    rd_tag_q;
  logic [7:0]          rd_data_q;

  logic                accept;
  logic                line_we;
  logic [7:0]          line_wdata;
  logic [IDX_W-1:0]    lat_idx;
  logic [TAG_W-1:0]    lat_tag;
  logic                hit;

  assign accept  = cache_req_ready && cache_req_valid;
  assign lat_idx = addr_q[IDX_W-1:0];
  assign lat_tag = addr_q[ADDR_W-1:IDX_W];
  // The tag/data read was registered at the accept edge, so it is ready in LOOKUP.
  assign hit     = valid_q[lat_idx] && (rd_tag_q == lat_tag);

  // State register and all registered outputs, async active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      bm_req_q     <= 1'b0;
      bm_we_q      <= 1'b0;
      bm_addr_q    <= '0;
      bm_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      bm_req_q     <= bm_req_d;
      bm_we_q      <= bm_we_d;
      bm_addr_q    <= bm_addr_d;
      bm_wdata_q   <= bm_wdata_d;
    end
  end

  // Next-state logic: a read hit returns straight to IDLE, everything else waits on memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cache_req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = (!we_q && hit) ? S_IDLE : S_MEM;
      S_MEM:    if (bm_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: request latch, memory port, response and line updates.
  always_comb begin
    cache_req_ready = (state_q == S_IDLE);
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = resp_data_q;
    bm_req_d        = bm_req_q;
    bm_we_d         = bm_we_q;
    bm_addr_d       = bm_addr_q;
    bm_wdata_d      = bm_wdata_q;
    line_we         = 1'b0;
    line_wdata      = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (cache_req_valid) begin
          we_d    = cache_req_we;
          addr_d  = cache_req_addr;
          wdata_d = cache_req_write;
        end
      end
      S_LOOKUP: begin
        if (we_q) begin
          // Write-allocate: the line takes the new byte whether or not it hit.
          line_we    = 1'b1;
          line_wdata = wdata_q;
          bm_req_d   = 1'b1;
          bm_we_d    = 1'b1;
          bm_addr_d  = addr_q;
          bm_wdata_d = wdata_q;
        end else if (hit) begin
          resp_data_d  = rd_data_q;
          resp_valid_d = 1'b1;
        end else begin
          bm_req_d  = 1'b1;
          bm_we_d   = 1'b0;
          bm_addr_d = addr_q;
        end
      end
      S_MEM: begin
        if (bm_ack) begin
          bm_req_d     = 1'b0;
          resp_valid_d = 1'b1;
          if (we_q) begin
            resp_data_d = wdata_q;
          end else begin
            line_we     = 1'b1;
            line_wdata  = bm_rdata;
            resp_data_d = bm_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Per-line valid bits; any line write marks the indexed line valid.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      assign valid_d[gi] = valid_q[gi] | (line_we && (lat_idx == IDX_W'(gi)));
      // Valid bit register, cleared by reset.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) valid_q[gi] <= 1'b0;
        else         valid_q[gi] <= valid_d[gi];
      end
    end
  endgenerate

  // Tag/data array: write on fill or store, registered read at accept.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= line_wdata;
    end
    if (accept) begin
      rd_tag_q  <= tag_mem[cache_req_addr[IDX_W-1:0]];
      rd_data_q <= data_mem[cache_req_addr[IDX_W-1:0]];
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating hit/miss counters, updated once per lookup.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_LOOKUP) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

  assign cache_resp_valid = resp_valid_q;
  assign cache_resp_data  = resp_data_q;
  assign bm_req           = bm_req_q;
  assign bm_we            = bm_we_q;
  assign bm_addr          = bm_addr_q;
  assign bm_wdata         = bm_wdata_q;

endmodule
